// File: rtl/uart_pkg.sv
// Constants and state encodings shared by the UART transmitter and receiver.
package uart_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int   UART_OVERSAMPLE = 16;
    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Clock-enable generator: one-cycle tick every CLK_DIV clocks, restartable via clr.
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 27
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int                DIV_W   = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;

    always_ff @(posedge clk_in) begin
        if (!rst || clr) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == DIV_MAX) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // With CLK_DIV=1 the counter sits at zero and tick is permanently high.
    assign tick = (div_cnt_reg == DIV_MAX);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART serializer with valid/ready host side and a registered serial output.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_out
);

    localparam int              OS_W    = cnt_width(OVERSAMPLE);
    localparam int              IDX_W   = cnt_width(DATA_BITS);
    localparam logic [OS_W-1:0] OS_MAX  = OS_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

    logic [2:0]           state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [OS_W-1:0]      os_cnt_reg, os_cnt_next;
    logic                 tx_out_reg, tx_ready_reg, tx_busy_reg, tx_done_reg;
    logic                 line_next;
    logic                 tick;
    logic                 accept;
    logic                 bit_end;

    assign accept  = tx_valid && tx_ready_reg;
    assign bit_end = tick && (os_cnt_reg == OS_MAX);

    uart_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_in (clk_in),
        .rst    (rst),
        .clr    (accept),
        .tick   (tick)
    );

    always_comb begin
        os_cnt_next = os_cnt_reg;
        if (accept) begin
            os_cnt_next = '0;
        end else if (tick) begin
            os_cnt_next = (os_cnt_reg == OS_MAX) ? '0 : os_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    shift_next = tx_data;
                    idx_next   = '0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (idx_reg == IDX_MAX) begin
                        state_next = S_STOP;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered with it, so
    // they change on the same edge as the state and never glitch.
    always_comb begin
        line_next = UART_IDLE_LEVEL;
        case (state_next)
            S_START: line_next = 1'b0;
            S_DATA:  line_next = shift_next[0];
            default: line_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            shift_reg    <= '0;
            idx_reg      <= '0;
            os_cnt_reg   <= '0;
            tx_out_reg   <= UART_IDLE_LEVEL;
            tx_ready_reg <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_done_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            idx_reg      <= idx_next;
            os_cnt_reg   <= os_cnt_next;
            tx_out_reg   <= line_next;
            tx_ready_reg <= (state_next == S_IDLE);
            tx_busy_reg  <= (state_next != S_IDLE);
            tx_done_reg  <= (state_next == S_DONE);
        end
    end

    assign tx_out   = tx_out_reg;
    assign tx_ready = tx_ready_reg;
    assign tx_busy  = tx_busy_reg;
    assign tx_done  = tx_done_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench: two transmitters (CLK_DIV=4 and CLK_DIV=1) checked cycle by cycle.
module tb_uart_transmitter;

    localparam int BT_A = 4 * 16;
    localparam int BT_B = 1 * 16;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       sel;
    logic       valid;
    logic [7:0] data;
    logic       valid_a, valid_b;
    logic       ready_a, busy_a, done_a, out_a;
    logic       ready_b, busy_b, done_b, out_b;
    logic       cur_ready, cur_busy, cur_done, cur_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt_b = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    assign valid_a   = valid & ~sel;
    assign valid_b   = valid & sel;
    assign cur_ready = sel ? ready_b : ready_a;
    assign cur_busy  = sel ? busy_b  : busy_a;
    assign cur_done  = sel ? done_b  : done_a;
    assign cur_out   = sel ? out_b   : out_a;

    uart_transmitter #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8)) dut_a (
        .clk_in   (clk),
        .rst      (rst_a),
        .tx_valid (valid_a),
        .tx_data  (data),
        .tx_ready (ready_a),
        .tx_busy  (busy_a),
        .tx_done  (done_a),
        .tx_out   (out_a)
    );

    uart_transmitter #(.CLK_DIV(1), .OVERSAMPLE(16), .DATA_BITS(8)) dut_b (
        .clk_in   (clk),
        .rst      (rst_b),
        .tx_valid (valid_b),
        .tx_data  (data),
        .tx_ready (ready_b),
        .tx_busy  (busy_b),
        .tx_done  (done_b),
        .tx_out   (out_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the accept edge; walks the whole frame plus DONE and return to IDLE.
    task automatic check_frame(input logic [7:0] d, input int bt, input string tag,
                               input int chg_at, input logic [7:0] chg_val, input int pulse_at,
                               output int start_cyc, output int lows);
        int         bad_line = 0;
        int         bad_ctl  = 0;
        logic [7:0] rx       = '0;
        logic       exp;
        int         bi;
        lows = 0;
        start_cyc = cyc;
        for (int k = 0; k < 10 * bt; k++) begin
            bi  = k / bt;
            exp = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : d[bi-1];
            if (cur_out !== exp) bad_line++;
            if (cur_busy !== 1'b1 || cur_done !== 1'b0 || cur_ready !== 1'b0) bad_ctl++;
            if (cur_out === 1'b0) lows++;
            if ((k % bt) == bt / 2 && bi >= 1 && bi <= 8) rx[bi-1] = cur_out;
            if (k == chg_at) data = chg_val;
            if (pulse_at >= 0 && k == pulse_at) valid = 1'b1;
            if (pulse_at >= 0 && k == pulse_at + 1) valid = 1'b0;
            step();
        end
        check_eq({tag, " line cycles wrong"}, bad_line, 0);
        check_eq({tag, " ctl cycles wrong"}, bad_ctl, 0);
        check_eq({tag, " rx byte"}, {24'd0, rx}, {24'd0, d});
        check_eq({tag, " done pulse"}, {28'd0, cur_done, cur_busy, cur_ready, cur_out}, 32'b1101);
        step();
        check_eq({tag, " back idle"}, {28'd0, cur_done, cur_busy, cur_ready, cur_out}, 32'b0011);
    endtask

    task automatic send(input logic [7:0] d, input int bt, input string tag, output int lows);
        int s;
        check_eq({tag, " ready before"}, {31'd0, cur_ready}, 1);
        valid = 1'b1;
        data  = d;
        step();
        valid = 1'b0;
        check_frame(d, bt, tag, -1, 8'h00, -1, s, lows);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, s1, s2, done_seen;
        rst_a = 1'b0;
        rst_b = 1'b0;
        sel   = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) step();
        check_eq("reset a", {28'd0, done_a, busy_a, ready_a, out_a}, 32'b0011);
        check_eq("reset b", {28'd0, done_b, busy_b, ready_b, out_b}, 32'b0011);
        rst_a = 1'b1;
        rst_b = 1'b1;
        step();

        send(8'hA5, BT_A, "a5", lows);
        send(8'h00, BT_A, "lb00", lows);
        check_eq("lb00 low cycles", lows, 9 * BT_A);
        send(8'hFF, BT_A, "lbff", lows);
        check_eq("lbff low cycles", lows, BT_A);

        // valid held high across two frames, data swapped mid-frame
        valid = 1'b1;
        data  = 8'h3C;
        step();
        check_frame(8'h3C, BT_A, "b2b1", 300, 8'hC3, -1, s1, lows);
        step();
        valid = 1'b0;
        check_frame(8'hC3, BT_A, "b2b2", -1, 8'h00, -1, s2, lows);
        check_eq("b2b spacing", s2 - s1, 10 * BT_A + 2);

        // abandon a frame during data bit 3
        valid = 1'b1;
        data  = 8'h5A;
        step();
        valid = 1'b0;
        repeat (4 * BT_A + BT_A / 2) step();
        check_eq("5a bit3 level", {31'd0, out_a}, 1);
        rst_a = 1'b0;
        step();
        check_eq("midframe reset", {28'd0, done_a, busy_a, ready_a, out_a}, 32'b0011);
        rst_a = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 2 * BT_A; k++) begin
            if (done_a) done_seen++;
            step();
        end
        check_eq("no done after reset", done_seen, 0);
        send(8'h81, BT_A, "81", lows);

        // reset and valid in the same cycle
        rst_a = 1'b0;
        valid = 1'b1;
        data  = 8'hFF;
        step();
        rst_a = 1'b0;
        valid = 1'b0;
        check_eq("rst wins", {28'd0, done_a, busy_a, ready_a, out_a}, 32'b0011);
        rst_a = 1'b1;
        step();
        check_eq("rst wins after", {28'd0, done_a, busy_a, ready_a, out_a}, 32'b0011);

        // CLK_DIV=1 instance
        sel = 1'b1;
        step();
        send(8'h96, BT_B, "div1 96", lows);
        valid = 1'b1;
        data  = 8'h5A;
        step();
        valid = 1'b0;
        check_frame(8'h5A, BT_B, "div1 pulse", -1, 8'h00, 20, s1, lows);
        repeat (40) step();
        check_eq("div1 frame count", done_cnt_b, 2);
        check_eq("div1 nothing queued", {31'd0, busy_b}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
